divider_inverse: RTL

- Sequential shift-add multiply-accumulate; the reverse direction of the team's 8-bit sequential divider.
- Rebuilds the dividend from a divider result: P = Q*B + R.
- Uses the same start/ok handshake and err convention as the divider.
- Used as a functional self-check stage: feed divider outputs D/R plus the divisor in, compare P against the original dividend.

---
 rtl/divider_inverse_pkg.sv | 22 ++
 rtl/divider_inverse_dp.sv | 58 +++++
 rtl/divider_inverse.sv | 92 +++++++++
 3 files changed

// File: rtl/divider_inverse_pkg.sv
// Shared definitions for the divider-inverse (multiply-accumulate) block:
// FSM state codes, default operand width and the result bundle handed to
// the comparator that checks the reconstructed dividend.
package divider_inverse_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_ADD  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  typedef struct packed {
    logic [2*DIV_WIDTH-1:0] p;
    logic                   ovf;
    logic                   err;
  } result_t;

endpackage

// File: rtl/divider_inverse_dp.sv
// Datapath for the divider inverse: shift-add multiplier (Q*B) followed by a
// single wide add of the remainder. Control strobes come from the top FSM.
module divider_inverse_dp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   r,
  output logic [2*WIDTH-1:0] p,
  output logic               ovf
);

  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   r_reg;
  logic [WIDTH:0]     sum_hi;
  logic [2*WIDTH-1:0] final_sum;

  // Conditional add of the multiplicand into the high half, carry kept in the extra bit
  always_comb begin
    sum_hi = {1'b0, acc_hi};
    if (acc_lo[0]) begin
      sum_hi = {1'b0, acc_hi} + {1'b0, q_reg};
    end
  end

  // Product plus remainder; the largest value still fits in 2*WIDTH bits
  assign final_sum = {acc_hi, acc_lo} + {{WIDTH{1'b0}}, r_reg};

  // Accumulator shifting, operand capture and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_hi <= '0;
      acc_lo <= '0;
      q_reg  <= '0;
      r_reg  <= '0;
      p      <= '0;
      ovf    <= 1'b0;
    end else if (load) begin
      acc_hi <= '0;
      acc_lo <= b;
      q_reg  <= q;
      r_reg  <= r;
    end else if (step) begin
      {acc_hi, acc_lo} <= {sum_hi, acc_lo[WIDTH-1:1]};
    end else if (finish) begin
      p   <= final_sum;
      ovf <= |final_sum[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/divider_inverse.sv
// Divider inverse: rebuilds the dividend P = Q*B + R from a divider result.
// Same start/ok handshake and err flag as the sequential divider, so it can
// sit directly behind it as a self-check stage.
module divider_inverse
  import divider_inverse_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   R,
  output logic [2*WIDTH-1:0] P,
  output logic               ok,
  output logic               done,
  output logic               ovf,
  output logic               err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          step;
  logic          finish;

  assign ok     = (state == ST_IDLE) || (state == ST_DONE);
  assign accept = ok && start;
  assign step   = (state == ST_MUL);
  assign finish = (state == ST_ADD);

  // Sequencing: accept, WIDTH multiply steps, final add, then report
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_MUL;
            cnt   <= CW'(WIDTH - 1);
            err   <= (R >= B);
          end
        end
        ST_MUL: begin
          if (cnt == '0) begin
            state <= ST_ADD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ADD: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: begin
          if (start) begin
            state <= ST_MUL;
            cnt   <= CW'(WIDTH - 1);
            err   <= (R >= B);
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  divider_inverse_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   (step),
    .finish (finish),
    .q      (Q),
    .b      (B),
    .r      (R),
    .p      (P),
    .ovf    (ovf)
  );

endmodule
